// File: rtl/systolic_result_drain.sv
// Purpose: snapshot the systolic multiplier's NxN result on a rising done and stream it row-major over valid/ready.
// Latency: first element is valid one cycle after the sampled done rise; back-to-back frames have no bubble.
// Backpressure: m_ready low holds all outputs stable; a result arriving mid-stream is dropped and flagged as overrun.
module systolic_result_drain #(
    parameter int N          = 3,
    parameter int DATA_WIDTH = 16,
    parameter int IDX_W      = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] matrix_c [N][N],
    input  logic                  done,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [IDX_W-1:0]      m_row,
    output logic [IDX_W-1:0]      m_col,
    output logic                  busy,
    output logic                  overrun,
    input  logic                  clear_overrun,
    output logic [15:0]           frame_count
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t                state_q, state_d;
    logic                  done_q;
    logic                  rise;
    logic [DATA_WIDTH-1:0] buf_q [N][N];
    logic [DATA_WIDTH-1:0] buf_d [N][N];
    logic [IDX_W-1:0]      row_q, row_d;
    logic [IDX_W-1:0]      col_q, col_d;
    logic                  overrun_q, overrun_d;
    logic [15:0]           frame_q, frame_d;
    logic                  last_elem;
    logic                  xfer;
    logic                  capture;
    logic                  overrun_set;

    assign rise = done & ~done_q;

    // Output view of the stream: everything is derived from registered state, so stalls hold it stable.
    always_comb begin
        m_valid   = (state_q == S_STREAM);
        busy      = (state_q == S_STREAM);
        last_elem = (row_q == LAST_IDX) && (col_q == LAST_IDX);
        m_last    = m_valid & last_elem;
        m_data    = m_valid ? buf_q[row_q][col_q] : '0;
        m_row     = m_valid ? row_q : '0;
        m_col     = m_valid ? col_q : '0;
        overrun   = overrun_q;
        frame_count = frame_q;
        xfer      = m_valid & m_ready;
    end

    // Next-state: capture on rise when free (or on the final transfer), walk row-major on each transfer.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        overrun_d   = overrun_q;
        frame_d     = frame_q;
        capture     = 1'b0;
        overrun_set = 1'b0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                buf_d[r][c] = buf_q[r][c];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    capture = 1'b1;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (xfer) begin
                    if (last_elem) begin
                        frame_d = frame_q + 16'd1;
                        row_d   = '0;
                        col_d   = '0;
                        // A rise coinciding with the final transfer is accepted without a bubble.
                        if (rise) begin
                            capture = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else if (col_q == LAST_IDX) begin
                        col_d = '0;
                        row_d = row_q + IDX_W'(1);
                    end else begin
                        col_d = col_q + IDX_W'(1);
                    end
                end
                // Any other rise while streaming would corrupt the frame in flight, so it is dropped.
                if (rise && !(xfer && last_elem)) begin
                    overrun_set = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Set takes priority over clear so a simultaneous drop is never lost.
        if (clear_overrun) begin
            overrun_d = 1'b0;
        end
        if (overrun_set) begin
            overrun_d = 1'b1;
        end

        if (capture) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    buf_d[r][c] = matrix_c[r][c];
                end
            end
        end
    end

    // State registers; done_q resets high so a done held across reset is not seen as a new result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            done_q    <= 1'b1;
            row_q     <= '0;
            col_q     <= '0;
            overrun_q <= 1'b0;
            frame_q   <= '0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    buf_q[r][c] <= '0;
                end
            end
        end else begin
            state_q   <= state_d;
            done_q    <= done;
            row_q     <= row_d;
            col_q     <= col_d;
            overrun_q <= overrun_d;
            frame_q   <= frame_d;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    buf_q[r][c] <= buf_d[r][c];
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain with N=3, DATA_WIDTH=16.
// Inputs change 1ns after the rising edge; outputs are checked at that same point.
// Expected values are hand-derived from the matrix contents and the row-major order.
module tb_systolic_result_drain;

    localparam int N  = 3;
    localparam int DW = 16;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] mat [N][N];
    logic          done = 1'b1;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          m_last;
    logic [IW-1:0] m_row;
    logic [IW-1:0] m_col;
    logic          busy;
    logic          overrun;
    logic          clear_overrun = 1'b0;
    logic [15:0]   frame_count;

    int tests = 0;
    int fails = 0;
    int exp_frames = 0;

    systolic_result_drain #(.N(N), .DATA_WIDTH(DW), .IDX_W(IW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .matrix_c      (mat),
        .done          (done),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_last        (m_last),
        .m_row         (m_row),
        .m_col         (m_col),
        .busy          (busy),
        .overrun       (overrun),
        .clear_overrun (clear_overrun),
        .frame_count   (frame_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int base);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                mat[r][c] = DW'(base + r * N + c);
    endtask

    task automatic fill(input logic [DW-1:0] v);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                mat[r][c] = v;
    endtask

    task automatic chk_elem(input string tag, input int v, input int r, input int c);
        chk({tag, "_valid"}, {31'd0, m_valid}, 32'd1);
        chk({tag, "_data"},  {16'd0, m_data}, v);
        chk({tag, "_row"},   {30'd0, m_row}, r);
        chk({tag, "_col"},   {30'd0, m_col}, c);
        chk({tag, "_last"},  {31'd0, m_last}, ((r == N - 1) && (c == N - 1)) ? 32'd1 : 32'd0);
    endtask

    // Requires done to have been low on the previous edge; leaves the first element presented.
    task automatic start_frame(input string tag);
        done = 1'b1;
        chk({tag, "_pre_valid"}, {31'd0, m_valid}, 32'd0);
        tick();
        done = 1'b0;
        chk({tag, "_first_valid"}, {31'd0, m_valid}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    endtask

    task automatic stream_full(input string tag, input int base);
        m_ready = 1'b1;
        for (int k = 0; k < N * N; k++) begin
            chk_elem(tag, base + k, k / N, k % N);
            tick();
        end
        exp_frames++;
        chk({tag, "_end_valid"}, {31'd0, m_valid}, 32'd0);
        chk({tag, "_end_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_frames"}, {16'd0, frame_count}, exp_frames);
    endtask

    initial begin
        int idx;
        int cyc;

        // Reset held 3 cycles with done high; done stays high afterwards.
        load(1);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("rst_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frames", {16'd0, frame_count}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_last", {31'd0, m_last}, 32'd0);
        chk("rst_data", {16'd0, m_data}, 32'd0);
        repeat (3) tick();
        chk("rst_done_held_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_done_held_busy", {31'd0, busy}, 32'd0);

        // Reset mid-stream at element 5; frame count is 0 both before and after.
        done = 1'b0;
        tick();
        start_frame("t6");
        m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk_elem("t6_pre", k + 1, k / N, k % N);
            tick();
        end
        chk_elem("t6_e5", 5, 1, 1);
        reset_n = 1'b0;
        #1;
        chk("t6_abort_valid", {31'd0, m_valid}, 32'd0);
        chk("t6_abort_busy", {31'd0, busy}, 32'd0);
        chk("t6_abort_frames", {16'd0, frame_count}, exp_frames);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        load(21);
        tick();
        start_frame("t6_fresh");
        stream_full("t6_fresh", 21);

        // Basic frame with ready held high.
        load(1);
        start_frame("t2");
        stream_full("t2", 1);

        // Ready pattern 1,0,0 repeating; source matrix overwritten after capture.
        load(1);
        start_frame("t3");
        fill(16'hFFFF);
        idx = 0;
        cyc = 0;
        while (idx < N * N && cyc < 100) begin
            m_ready = ((cyc % 3) == 0);
            chk_elem("t3", idx + 1, idx / N, idx % N);
            tick();
            if (m_ready) idx++;
            cyc++;
        end
        chk("t3_all_delivered", idx, N * N);
        exp_frames++;
        chk("t3_end_valid", {31'd0, m_valid}, 32'd0);
        chk("t3_frames", {16'd0, frame_count}, exp_frames);

        // Rise at element 4 while streaming: dropped and flagged.
        load(1);
        m_ready = 1'b1;
        start_frame("t4");
        for (int k = 0; k < N * N; k++) begin
            chk_elem("t4", k + 1, k / N, k % N);
            if (k == 3) done = 1'b1;
            tick();
        end
        done = 1'b0;
        exp_frames++;
        chk("t4_overrun_set", {31'd0, overrun}, 32'd1);
        chk("t4_end_valid", {31'd0, m_valid}, 32'd0);
        chk("t4_frames", {16'd0, frame_count}, exp_frames);
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        chk("t4_overrun_cleared", {31'd0, overrun}, 32'd0);

        // Clear and set in the same cycle: set wins.
        start_frame("t4b");
        for (int k = 0; k < N * N; k++) begin
            chk_elem("t4b", k + 1, k / N, k % N);
            if (k == 2) begin
                done = 1'b1;
                clear_overrun = 1'b1;
            end
            tick();
            clear_overrun = 1'b0;
            if (k == 2) chk("t4b_set_wins", {31'd0, overrun}, 32'd1);
        end
        done = 1'b0;
        exp_frames++;
        chk("t4b_overrun_held", {31'd0, overrun}, 32'd1);
        chk("t4b_frames", {16'd0, frame_count}, exp_frames);
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        chk("t4b_overrun_cleared", {31'd0, overrun}, 32'd0);

        // Rise on the final transfer edge: next frame follows with no bubble.
        load(1);
        start_frame("t5");
        for (int k = 0; k < N * N; k++) begin
            chk_elem("t5", k + 1, k / N, k % N);
            if (k == N * N - 1) begin
                done = 1'b1;
                load(10);
            end
            tick();
        end
        done = 1'b0;
        exp_frames++;
        chk("t5_no_bubble_valid", {31'd0, m_valid}, 32'd1);
        chk("t5_frames_mid", {16'd0, frame_count}, exp_frames);
        stream_full("t5_second", 10);
        chk("t5_no_overrun", {31'd0, overrun}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
